// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

  localparam int WIDTH = 16;
  localparam int CNTW  = $clog2(WIDTH) + 1;

  // {Q[0], Q[-1]} pairs that need an add or subtract before the shift
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_M = 4'd1,
    LOAD_Q = 4'd2,
    EVAL   = 4'd3,
    ADD    = 4'd4,
    SUB    = 4'd5,
    SHIFT  = 4'd6,
    DONE   = 4'd7,
    ABORT  = 4'd8
  } state_e;

endpackage

// File: rtl/booth_ctrl.sv
// Booth sequencer: LOAD_Q handshake to done takes 2*WIDTH + k + 2 cycles (k = add/sub visits).
// Operand loads stall on in_valid with in_ready held high; abort wins over in_valid and eqz.
module booth_ctrl
  import booth_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  output logic in_ready,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
  output logic ldA,
  output logic ldQ,
  output logic ldM,
  output logic clrA,
  output logic clrQ,
  output logic clrff,
  output logic sftA,
  output logic sftQ,
  output logic addsub,
  output logic decr,
  output logic ldcnt,
  output logic busy,
  output logic done
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    ldA      = 1'b0;
    ldQ      = 1'b0;
    ldM      = 1'b0;
    clrA     = 1'b0;
    clrQ     = 1'b0;
    clrff    = 1'b0;
    sftA     = 1'b0;
    sftQ     = 1'b0;
    addsub   = 1'b0;
    decr     = 1'b0;
    ldcnt    = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_M;
      end

      // Handshake strobes are held off entirely on an abort cycle.
      LOAD_M: begin
        if (abort) begin
          state_d = ABORT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            ldM     = 1'b1;
            state_d = LOAD_Q;
          end
        end
      end

      LOAD_Q: begin
        if (abort) begin
          state_d = ABORT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            ldQ     = 1'b1;
            clrA    = 1'b1;
            clrff   = 1'b1;
            ldcnt   = 1'b1;
            state_d = EVAL;
          end
        end
      end

      EVAL: begin
        if (abort) begin
          state_d = ABORT;
        end else if (eqz) begin
          state_d = DONE;
        end else begin
          case ({q0, qm1})
            BOOTH_ADD: state_d = ADD;
            BOOTH_SUB: state_d = SUB;
            default:   state_d = SHIFT;
          endcase
        end
      end

      ADD: begin
        ldA     = 1'b1;
        addsub  = 1'b1;
        state_d = abort ? ABORT : SHIFT;
      end

      SUB: begin
        ldA     = 1'b1;
        addsub  = 1'b0;
        state_d = abort ? ABORT : SHIFT;
      end

      SHIFT: begin
        sftA    = 1'b1;
        sftQ    = 1'b1;
        decr    = 1'b1;
        state_d = abort ? ABORT : EVAL;
      end

      DONE: begin
        done    = 1'b1;
        state_d = abort ? ABORT : IDLE;
      end

      ABORT: begin
        clrA    = 1'b1;
        clrQ    = 1'b1;
        clrff   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
